// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the divider sequencer.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'b00,
    DivCtrlBusy  = 2'b01,
    DivCtrlDone  = 2'b10,
    DivCtrlDrain = 2'b11
  } div_ctrl_state_e;

  localparam logic RstEnable      = 1'b1;
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

endpackage

// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and the multi-cycle divider: issues start/annul, stalls the
// pipeline until the result is back, and presents the registered result as a HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_div_i,
  input  logic        is_divu_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        ex_hold_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        signed_div_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] busy_cycles_o
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

  div_ctrl_state_e state_q, state_d;
  logic [63:0]     res_q, res_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic [31:0]     busy_q;
  logic            req;

  assign req           = (is_div_i | is_divu_i) & ~flush_i;
  assign busy_cycles_o = busy_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= DivCtrlIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Result, drain counter and BUSY performance counter.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      res_q   <= '0;
      drain_q <= '0;
      busy_q  <= '0;
    end else begin
      res_q   <= res_d;
      drain_q <= drain_d;
      if (state_q == DivCtrlBusy) begin
        busy_q <= busy_q + 32'd1;
      end
    end
  end

  // Next-state logic; flush wins over ready while busy.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    drain_d = drain_q;
    unique case (state_q)
      DivCtrlIdle: begin
        if (req) state_d = DivCtrlBusy;
      end
      DivCtrlBusy: begin
        if (flush_i) begin
          state_d = DivCtrlDrain;
          drain_d = CntW'(DRAIN_CYCLES);
        end else if (div_ready_i == DivResultReady) begin
          state_d = DivCtrlDone;
          res_d   = div_result_i;
        end
      end
      DivCtrlDone: begin
        if (flush_i || !ex_hold_i) state_d = DivCtrlIdle;
      end
      DivCtrlDrain: begin
        drain_d = drain_q - CntW'(1);
        // Leave once the decremented count reaches 1; the annul cycle in BUSY plus the drain
        // cycles keep start low for DRAIN_CYCLES cycles in total.
        if (drain_q <= CntW'(2)) state_d = DivCtrlIdle;
      end
      default: ;
    endcase
  end

  // Output decode.
  always_comb begin
    div_start_o   = DivStop;
    div_annul_o   = 1'b0;
    signed_div_o  = 1'b0;
    div_opdata1_o = '0;
    div_opdata2_o = '0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = '0;
    lo_o          = '0;
    unique case (state_q)
      DivCtrlIdle: begin
        if (req) begin
          div_start_o   = DivStart;
          signed_div_o  = is_div_i;
          div_opdata1_o = reg1_i;
          div_opdata2_o = reg2_i;
          stallreq_o    = 1'b1;
        end
      end
      DivCtrlBusy: begin
        signed_div_o  = is_div_i;
        div_opdata1_o = reg1_i;
        div_opdata2_o = reg2_i;
        if (flush_i) begin
          div_annul_o = 1'b1;
        end else if (div_ready_i != DivResultReady) begin
          div_start_o = DivStart;
          stallreq_o  = 1'b1;
        end
      end
      DivCtrlDone: begin
        // A flushed instruction must not commit its HI/LO write.
        whilo_o = ~flush_i;
        hi_o    = res_q[63:32];
        lo_o    = res_q[31:0];
      end
      DivCtrlDrain: begin
        div_annul_o = 1'b1;
        stallreq_o  = req;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against a behavioural divider and arithmetic model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_div, is_divu, flush, ex_hold;
  logic [31:0] reg1, reg2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_start, div_annul, signed_div, stallreq, whilo;
  logic [31:0] op1, op2, hi, lo, busy_cycles;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_busy;

  div_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .is_div_i      (is_div),
    .is_divu_i     (is_divu),
    .reg1_i        (reg1),
    .reg2_i        (reg2),
    .flush_i       (flush),
    .ex_hold_i     (ex_hold),
    .div_result_i  (div_result),
    .div_ready_i   (div_ready),
    .div_start_o   (div_start),
    .div_annul_o   (div_annul),
    .signed_div_o  (signed_div),
    .div_opdata1_o (op1),
    .div_opdata2_o (op2),
    .stallreq_o    (stallreq),
    .whilo_o       (whilo),
    .hi_o          (hi),
    .lo_o          (lo),
    .busy_cycles_o (busy_cycles)
  );

  always #5 clk = ~clk;

  // {remainder, quotient} with truncating division; divide by zero gives zeros.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Divider model: ready 34 cycles after start (3 for a zero divisor), held until start drops.
  // A zero-divisor divide cannot be annulled in its first cycle and needs start low to free.
  logic        m_busy, m_zero;
  int          m_k;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (div_start && !div_annul) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_zero <= (op2 == 32'd0);
        m_res  <= ref_div(signed_div, op1, op2);
      end
    end else if ((div_annul || !div_start) && !(m_zero && m_k == 1)) begin
      m_busy <= 1'b0;
    end else if (m_k < (m_zero ? 3 : 34)) begin
      m_k <= m_k + 1;
    end
  end

  assign div_ready  = m_busy && (m_k >= (m_zero ? 3 : 34));
  assign div_result = div_ready ? m_res : 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {div_start, div_annul, signed_div, stallreq, whilo}, 64'd0);
    chk({tag, "_res"}, {hi, lo}, 64'd0);
    chk({tag, "_ops"}, {op1, op2}, 64'd0);
  endtask

  // Issue one divide from EX, follow it to completion, hold it in DONE for `hold` cycles.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int lat, n;
    lat = (b == 32'd0) ? 3 : 34;
    @(negedge clk);
    is_div = sgn; is_divu = ~sgn; reg1 = a; reg2 = b; flush = 1'b0; ex_hold = 1'b0;
    #1;
    chk("issue_ctl", {div_start, div_annul, signed_div, stallreq}, {1'b1, 1'b0, sgn, 1'b1});
    chk("issue_ops", {op1, op2}, {a, b});
    n = 0;
    while (stallreq === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_len", 64'(n), 64'(lat));
    chk("ready_cyc", {div_start, whilo}, 64'd0);
    exp_busy += 32'(lat);
    @(negedge clk);
    ex_hold = (hold > 0);
    #1;
    chk("done_whilo", {whilo, div_start, stallreq}, 64'b100);
    chk("done_res", {hi, lo}, {e_hi, e_lo});
    chk("busy_cnt", busy_cycles, exp_busy);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      ex_hold = (i < hold);
      #1;
      chk("hold_whilo", {whilo, div_start, stallreq}, 64'b100);
      chk("hold_res", {hi, lo}, {e_hi, e_lo});
    end
    @(negedge clk);
    is_div = 1'b0; is_divu = 1'b0; reg1 = '0; reg2 = '0; ex_hold = 1'b0;
    #1;
    chk_quiet("retired");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] a, b;
    logic [63:0] r;

    rst = 1'b1; is_div = 1'b0; is_divu = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    reg1 = '0; reg2 = '0; exp_busy = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_busy", busy_cycles, 64'd0);

    // Directed divides.
    run_div(1'b0, 32'd7, 32'd2, 0, 32'd1, 32'd3);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(1'b1, 32'd5, 32'd0, 0, 32'd0, 32'd0);
    run_div(1'b0, 32'd1000, 32'd7, 3, 32'd6, 32'd142);

    // Flush on the 10th BUSY cycle, next divide waiting behind the drain.
    @(negedge clk);
    is_divu = 1'b1; reg1 = 32'd100; reg2 = 32'd3;
    #1;
    chk("fl_issue", {div_start, stallreq}, 64'b11);
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_annul", {div_annul, div_start, stallreq}, 64'b100);
    @(negedge clk);
    flush = 1'b0; reg1 = 32'd9; reg2 = 32'd4;
    #1;
    chk("fl_drain", {div_annul, div_start, stallreq}, 64'b101);
    exp_busy += 32'd10;
    run_div(1'b0, 32'd9, 32'd4, 0, 32'd1, 32'd2);

    // Flush the cycle after a divide-by-zero start; the next divide must not see stale ready.
    @(negedge clk);
    is_div = 1'b1; reg1 = 32'd5; reg2 = 32'd0;
    #1;
    chk("z_issue", {div_start, signed_div, stallreq}, 64'b111);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("z_annul", {div_annul, div_start}, 64'b10);
    @(negedge clk);
    flush = 1'b0; is_div = 1'b0; is_divu = 1'b1; reg1 = 32'd100; reg2 = 32'd7;
    #1;
    chk("z_drain", {div_annul, div_start, stallreq}, 64'b101);
    exp_busy += 32'd1;
    run_div(1'b0, 32'd100, 32'd7, 0, 32'd2, 32'd14);

    // Flush together with issue: nothing starts.
    @(negedge clk);
    is_div = 1'b1; flush = 1'b1; reg1 = 32'd8; reg2 = 32'd2;
    #1;
    chk("idle_flush", {div_start, div_annul, stallreq, whilo}, 64'd0);
    @(negedge clk);
    is_div = 1'b0; flush = 1'b0; reg1 = '0; reg2 = '0;
    #1;
    chk_quiet("idle_flush_after");

    // Randomized divides.
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom % 2);
      a = $urandom;
      b = ($urandom % 4 == 0) ? 32'd0 : ($urandom >> ($urandom % 32));
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      r = ref_div(s, a, b);
      run_div(s, a, b, int'($urandom % 3), r[63:32], r[31:0]);
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    is_divu = 1'b1; reg1 = 32'd50; reg2 = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; is_divu = 1'b0; reg1 = '0; reg2 = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("midreset");
    chk("midreset_busy", busy_cycles, 64'd0);
    exp_busy = '0;
    run_div(1'b0, 32'd50, 32'd5, 1, 32'd0, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
